// File: rtl/wave_shaper.sv
// Two-stage waveform shaper: stage 1 folds the phase address into a raw sample,
// stage 2 scales it by an ADSR-style (attack/sustain/release) envelope register.
module wave_shaper #(
  parameter logic [15:0] ENV_MAX = 16'hFFFF
) (
  input  logic        i_clk5MHz,
  input  logic        i_rst_n,
  input  logic [15:0] i_16bit_addr,
  input  logic [1:0]  i_wave_sel,
  input  logic [15:0] i_pulse_width,
  input  logic        i_gate,
  input  logic [15:0] i_attack_step,
  input  logic [15:0] i_release_step,
  output logic [15:0] o_sample,
  output logic        o_valid,
  output logic [15:0] o_env,
  output logic [1:0]  o_env_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ATTACK  = 2'b01,
    ST_SUSTAIN = 2'b10,
    ST_RELEASE = 2'b11
  } env_state_t;

  localparam int VALID_DEPTH = 2;

  env_state_t               r_state;
  logic [15:0]              r_env;
  logic [15:0]              r_raw;
  logic [15:0]              r_sample;
  logic [VALID_DEPTH-1:0]   r_valid_pipe;

  logic [15:0]        w_tri_fold;
  logic [15:0]        w_raw_next;
  logic [16:0]        w_attack_sum;
  logic               w_attack_done;
  logic               w_release_done;
  logic [15:0]        w_release_diff;
  logic signed [32:0] w_raw_ext;
  logic signed [32:0] w_env_ext;
  logic signed [32:0] w_product;

  // Triangle: double the low 15 bits, mirror the second half of the period.
  assign w_tri_fold = i_16bit_addr[15] ? ~{i_16bit_addr[14:0], 1'b0}
                                       :  {i_16bit_addr[14:0], 1'b0};

  always_comb begin
    w_raw_next = 16'h0000;
    case (i_wave_sel)
      2'b00:   w_raw_next = i_16bit_addr ^ 16'h8000;
      2'b01:   w_raw_next = (i_16bit_addr < i_pulse_width) ? 16'h7FFF : 16'h8000;
      2'b10:   w_raw_next = w_tri_fold ^ 16'h8000;
      default: w_raw_next = 16'h0000;
    endcase
  end

  assign w_attack_sum   = {1'b0, r_env} + {1'b0, i_attack_step};
  assign w_attack_done  = (i_attack_step == 16'd0) || (w_attack_sum >= {1'b0, ENV_MAX});
  assign w_release_done = (i_release_step == 16'd0) || (r_env <= i_release_step);
  assign w_release_diff = r_env - i_release_step;

  // Gate changes are checked before level-reached transitions in every state.
  always_ff @(posedge i_clk5MHz) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_env   <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_env <= 16'd0;
          if (i_gate) r_state <= ST_ATTACK;
        end
        ST_ATTACK: begin
          if (!i_gate) begin
            r_state <= ST_RELEASE;
          end else if (w_attack_done) begin
            r_env   <= ENV_MAX;
            r_state <= ST_SUSTAIN;
          end else begin
            r_env <= w_attack_sum[15:0];
          end
        end
        ST_SUSTAIN: begin
          r_env <= ENV_MAX;
          if (!i_gate) r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (i_gate) begin
            r_state <= ST_ATTACK;
          end else if (w_release_done) begin
            r_env   <= 16'd0;
            r_state <= ST_IDLE;
          end else begin
            r_env <= w_release_diff;
          end
        end
        default: begin
          r_env   <= 16'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Signed raw times unsigned envelope; the upper half is the scaled sample.
  assign w_raw_ext = {{17{r_raw[15]}}, r_raw};
  assign w_env_ext = {17'd0, r_env};
  assign w_product = w_raw_ext * w_env_ext;

  always_ff @(posedge i_clk5MHz) begin
    if (!i_rst_n) begin
      r_raw    <= 16'h0000;
      r_sample <= 16'h0000;
    end else begin
      r_raw    <= w_raw_next;
      r_sample <= 16'(w_product >>> 16);
    end
  end

  generate
    for (genvar gi = 0; gi < VALID_DEPTH; gi++) begin : g_valid
      if (gi == 0) begin : g_first
        always_ff @(posedge i_clk5MHz) begin
          if (!i_rst_n) r_valid_pipe[gi] <= 1'b0;
          else          r_valid_pipe[gi] <= 1'b1;
        end
      end else begin : g_next
        always_ff @(posedge i_clk5MHz) begin
          if (!i_rst_n) r_valid_pipe[gi] <= 1'b0;
          else          r_valid_pipe[gi] <= r_valid_pipe[gi-1];
        end
      end
    end
  endgenerate

  assign o_sample    = r_sample;
  assign o_valid     = r_valid_pipe[VALID_DEPTH-1];
  assign o_env       = r_env;
  assign o_env_state = r_state;

endmodule

// File: tb/tb_wave_shaper.sv
// Self-checking bench for wave_shaper: directed vector table, envelope sequences
// and randomized stimulus against an arithmetic reference model.
module tb_wave_shaper;

  localparam logic [15:0] ENV_MAX = 16'hFFFF;
  localparam int EMAX = 65535;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [1:0]  wave_sel;
  logic [15:0] pulse_width;
  logic        gate;
  logic [15:0] attack_step;
  logic [15:0] release_step;
  logic [15:0] sample;
  logic        valid;
  logic [15:0] env;
  logic [1:0]  env_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (spec-level quantities as plain integers).
  int          m_raw = 0;
  int          m_env = 0;
  int          m_state = 0;
  int          m_vcnt = 0;
  logic [15:0] m_sample = 16'h0000;

  wave_shaper #(.ENV_MAX(ENV_MAX)) dut (
    .i_clk5MHz     (clk),
    .i_rst_n       (rst_n),
    .i_16bit_addr  (addr),
    .i_wave_sel    (wave_sel),
    .i_pulse_width (pulse_width),
    .i_gate        (gate),
    .i_attack_step (attack_step),
    .i_release_step(release_step),
    .o_sample      (sample),
    .o_valid       (valid),
    .o_env         (env),
    .o_env_state   (env_state)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int shape(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] pw);
    int ai;
    int fold;
    ai = int'(a);
    case (sel)
      2'd0: return ai - 32768;
      2'd1: return (ai < int'(pw)) ? 32767 : -32768;
      2'd2: begin
        fold = (ai < 32768) ? 2 * ai : 65535 - 2 * (ai - 32768);
        return fold - 32768;
      end
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] scale(input int raw, input int e);
    longint p;
    logic [63:0] q;
    p = longint'(raw) * longint'(e);
    q = 64'(p >>> 16);
    return q[15:0];
  endfunction

  // One clock: predict, advance, then compare every output against the model.
  task automatic tick();
    int n_raw, n_env, n_state, n_vcnt;
    logic [15:0] n_sample;
    if (!rst_n) begin
      n_raw = 0; n_env = 0; n_state = 0; n_vcnt = 0; n_sample = 16'h0000;
    end else begin
      n_raw    = shape(wave_sel, addr, pulse_width);
      n_sample = scale(m_raw, m_env);
      n_vcnt   = (m_vcnt < 2) ? m_vcnt + 1 : 2;
      n_env    = m_env;
      n_state  = m_state;
      case (m_state)
        0: begin
          n_env = 0;
          if (gate) n_state = 1;
        end
        1: begin
          if (!gate) n_state = 3;
          else if (attack_step == 0 || m_env + int'(attack_step) >= EMAX) begin
            n_env = EMAX; n_state = 2;
          end else n_env = m_env + int'(attack_step);
        end
        2: begin
          n_env = EMAX;
          if (!gate) n_state = 3;
        end
        default: begin
          if (gate) n_state = 1;
          else if (release_step == 0 || m_env - int'(release_step) <= 0) begin
            n_env = 0; n_state = 0;
          end else n_env = m_env - int'(release_step);
        end
      endcase
    end
    @(posedge clk);
    #1;
    m_raw = n_raw; m_env = n_env; m_state = n_state; m_vcnt = n_vcnt; m_sample = n_sample;
    check16("model_sample", sample, m_sample);
    check16("model_valid", {15'd0, valid}, {15'd0, m_vcnt >= 2});
    check16("model_env", env, 16'(m_env));
    check16("model_state", {14'd0, env_state}, 16'(m_state));
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] a;
    logic [15:0] pw;
    logic [15:0] exp_sample;
  } vec_t;

  vec_t vecs[11];

  logic [15:0] exp_env_seq[5];
  logic [15:0] exp_st_seq[5];

  initial begin
    // Samples with envelope at full scale: upper half of raw * 0xFFFF.
    vecs[0]  = '{2'd0, 16'h0000, 16'h0000, 16'h8000};
    vecs[1]  = '{2'd0, 16'h8000, 16'h0000, 16'h0000};
    vecs[2]  = '{2'd0, 16'hFFFF, 16'h0000, 16'h7FFE};
    vecs[3]  = '{2'd1, 16'h3FFF, 16'h4000, 16'h7FFE};
    vecs[4]  = '{2'd1, 16'h4000, 16'h4000, 16'h8000};
    vecs[5]  = '{2'd1, 16'h0000, 16'h0000, 16'h8000};
    vecs[6]  = '{2'd2, 16'h0000, 16'h0000, 16'h8000};
    vecs[7]  = '{2'd2, 16'h4000, 16'h0000, 16'h0000};
    vecs[8]  = '{2'd2, 16'h7FFF, 16'h0000, 16'h7FFD};
    vecs[9]  = '{2'd2, 16'hFFFF, 16'h0000, 16'h8001};
    vecs[10] = '{2'd3, 16'h1234, 16'h0000, 16'h0000};

    rst_n = 1'b0; addr = 16'h0000; wave_sel = 2'd0; pulse_width = 16'h0000;
    gate = 1'b0; attack_step = 16'h0000; release_step = 16'h0000;

    tick(); tick();
    check16("reset_sample", sample, 16'h0000);
    check16("reset_valid", {15'd0, valid}, 16'h0000);
    check16("reset_env", env, 16'h0000);
    check16("reset_state", {14'd0, env_state}, 16'h0000);

    // Attack ramp with 0x4000 steps, then release with 0x8000 steps.
    exp_env_seq = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
    exp_st_seq  = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
    rst_n = 1'b1; gate = 1'b1; attack_step = 16'h4000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check16("attack_env", env, exp_env_seq[i]);
      check16("attack_state", {14'd0, env_state}, exp_st_seq[i]);
      check16("valid_rise", {15'd0, valid}, (i >= 1) ? 16'd1 : 16'd0);
      $display("attack step %0d env=%h state=%0d", i, env, env_state);
    end
    gate = 1'b0; release_step = 16'h8000;
    tick(); check16("rel_hold_env", env, 16'hFFFF); check16("rel_state", {14'd0, env_state}, 16'd3);
    tick(); check16("rel_env1", env, 16'h7FFF);
    tick(); check16("rel_env2", env, 16'h0000); check16("rel_idle", {14'd0, env_state}, 16'd0);

    // Retrigger: gate drops at 0x8000, comes back two cycles later.
    gate = 1'b1; attack_step = 16'h4000;
    tick(); tick(); tick();
    check16("retrig_pre", env, 16'h8000);
    gate = 1'b0; release_step = 16'h1000;
    tick(); check16("retrig_drop_env", env, 16'h8000); check16("retrig_drop_st", {14'd0, env_state}, 16'd3);
    tick(); check16("retrig_dec", env, 16'h7000);
    gate = 1'b1;
    tick(); check16("retrig_env", env, 16'h7000); check16("retrig_st", {14'd0, env_state}, 16'd1);
    tick(); check16("retrig_resume", env, 16'hB000);
    $display("retrigger env=%h state=%0d", env, env_state);

    // Gate drop wins over reaching the sustain level.
    gate = 1'b0; attack_step = 16'hF000;
    tick(); check16("prio_env", env, 16'hB000); check16("prio_st", {14'd0, env_state}, 16'd3);

    // Zero release step empties the envelope in one cycle.
    release_step = 16'h0000;
    tick(); check16("rel0_env", env, 16'h0000); check16("rel0_st", {14'd0, env_state}, 16'd0);

    // Zero attack step jumps to sustain; then reset pulsed mid-note.
    gate = 1'b1; attack_step = 16'h0000;
    tick(); tick();
    check16("att0_env", env, 16'hFFFF); check16("att0_st", {14'd0, env_state}, 16'd2);
    rst_n = 1'b0;
    tick();
    check16("rst_mid_env", env, 16'h0000); check16("rst_mid_st", {14'd0, env_state}, 16'd0);
    check16("rst_mid_sample", sample, 16'h0000); check16("rst_mid_valid", {15'd0, valid}, 16'd0);
    rst_n = 1'b1;
    tick();
    check16("post_rst_st", {14'd0, env_state}, 16'd1); check16("post_rst_valid", {15'd0, valid}, 16'd0);
    tick();
    check16("post_rst_valid2", {15'd0, valid}, 16'd1);
    tick();

    // Shaping table, envelope held at full scale.
    for (int i = 0; i < 11; i++) begin
      wave_sel = vecs[i].sel; addr = vecs[i].a; pulse_width = vecs[i].pw;
      tick(); tick();
      check16("vec_sample", sample, vecs[i].exp_sample);
      $display("vec %0d sel=%0d addr=%h pw=%h sample=%h expect=%h",
               i, vecs[i].sel, vecs[i].a, vecs[i].pw, sample, vecs[i].exp_sample);
    end

    // Randomized stimulus against the reference model.
    for (int c = 0; c < 3000; c++) begin
      addr = 16'($urandom);
      wave_sel = 2'($urandom_range(0, 3));
      pulse_width = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 24) == 0) gate = ~gate;
      attack_step  = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h3000));
      release_step = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h3000));
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
